l2c_flush_seq: RTL and testbench

//  Sequencer for the L2C tag/data array. It walks every index, writes each valid+dirty way

---
 rtl/l2c_flush_seq_pkg.sv | 34 +++
 rtl/l2c_way_penc.sv | 25 ++
 rtl/l2c_flush_seq.sv | 166 ++++++++++++++++
 tb/tb_l2c_flush_seq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2c_flush_seq_pkg.sv
// Shared types for the L2C flush/clean sequencer: FSM state encodings, XU command codes
// and default array geometry.
package l2c_flush_seq_pkg;

  localparam int L2C_INDEX_W = 8;
  localparam int L2C_WAY_NUM = 4;
  localparam int L2C_TAG_W   = 22;
  localparam int L2C_DATA_W  = 32;
  localparam int L2C_ADDR_W  = 32;

  typedef logic [L2C_INDEX_W-1:0] l2c_index_t;

  typedef enum logic [2:0] {
    L2C_FLUSH_ST_IDLE = 3'd0,
    L2C_FLUSH_ST_RD   = 3'd1,
    L2C_FLUSH_ST_SCAN = 3'd2,
    L2C_FLUSH_ST_WB   = 3'd3,
    L2C_FLUSH_ST_UPD  = 3'd4,
    L2C_FLUSH_ST_NEXT = 3'd5,
    L2C_FLUSH_ST_DONE = 3'd6
  } l2c_flush_st_e;

  typedef enum logic [1:0] {
    XU_L2C_CMD_RD = 2'd0,
    XU_L2C_CMD_WR = 2'd1,
    XU_L2C_CMD_WB = 2'd2
  } xu_l2c_cmd_e;

  // Way-number width; a single-way cache still needs a 1-bit way field.
  function automatic int way_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2c_way_penc.sv
// Lowest-set-bit priority encoder over the per-way pending mask.
module l2c_way_penc
  import l2c_flush_seq_pkg::*;
#(
  parameter int WAY_NUM = 4,
  parameter int WAY_W   = way_w(WAY_NUM)
) (
  input  logic [WAY_NUM-1:0] req,
  output logic               found,
  output logic [WAY_W-1:0]   way
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    found = 1'b0;
    way   = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        way   = WAY_W'(i);
      end
    end
  end

endmodule

// File: rtl/l2c_flush_seq.sv
// Walks every set of the L2C array, writes dirty lines back over the XU master port, then
// invalidates the set (flush) or just clears its dirty bits (clean).
module l2c_flush_seq
  import l2c_flush_seq_pkg::*;
#(
  parameter int INDEX_W = L2C_INDEX_W,
  parameter int WAY_NUM = L2C_WAY_NUM,
  parameter int TAG_W   = L2C_TAG_W,
  parameter int DATA_W  = L2C_DATA_W,
  parameter int ADDR_W  = L2C_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_rw_req,
  output logic [INDEX_W-1:0]        mem_rw_index,
  output logic [WAY_NUM-1:0]        mem_wr_en_pack,
  output logic [TAG_W*WAY_NUM-1:0]  mem_wr_tag_pack,
  output logic [WAY_NUM-1:0]        mem_wr_valid_pack,
  output logic [WAY_NUM-1:0]        mem_wr_dirty_pack,
  output logic [DATA_W*WAY_NUM-1:0] mem_wr_data_pack,
  input  logic                      mem_rw_rdy,
  input  logic [TAG_W*WAY_NUM-1:0]  mem_rd_tag_pack,
  input  logic [WAY_NUM-1:0]        mem_rd_valid_pack,
  input  logic [WAY_NUM-1:0]        mem_rd_dirty_pack,
  input  logic [DATA_W*WAY_NUM-1:0] mem_rd_data_pack,
  output logic                      xu_req,
  output xu_l2c_cmd_e               xu_cmd,
  output logic [ADDR_W-1:0]         xu_addr,
  output logic [DATA_W/8-1:0]       xu_data_be,
  output logic [DATA_W-1:0]         xu_data,
  input  logic                      xu_ack
);

  localparam int WAY_W = way_w(WAY_NUM);

  l2c_flush_st_e              state;
  logic [INDEX_W-1:0]         idx;
  logic                       mode_r;
  logic [TAG_W*WAY_NUM-1:0]   cap_tag;
  logic [DATA_W*WAY_NUM-1:0]  cap_data;
  logic [WAY_NUM-1:0]         cap_valid;
  logic [WAY_NUM-1:0]         pend;
  logic                       had_pend;
  logic [WAY_W-1:0]           way_sel;
  logic                       pend_found;
  logic [WAY_W-1:0]           pend_way;

  l2c_way_penc #(
    .WAY_NUM (WAY_NUM),
    .WAY_W   (WAY_W)
  ) u_penc (
    .req   (pend),
    .found (pend_found),
    .way   (pend_way)
  );

  assign mem_rw_index = idx;
  assign xu_cmd       = XU_L2C_CMD_WB;
  assign xu_data_be   = '1;

  // Clean mode skips the array write when the set had nothing to write back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= L2C_FLUSH_ST_IDLE;
      idx               <= '0;
      mode_r            <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      mem_rw_req        <= 1'b0;
      mem_wr_en_pack    <= '0;
      mem_wr_tag_pack   <= '0;
      mem_wr_valid_pack <= '0;
      mem_wr_dirty_pack <= '0;
      mem_wr_data_pack  <= '0;
      xu_req            <= 1'b0;
      xu_addr           <= '0;
      xu_data           <= '0;
      cap_tag           <= '0;
      cap_data          <= '0;
      cap_valid         <= '0;
      pend              <= '0;
      had_pend          <= 1'b0;
      way_sel           <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        L2C_FLUSH_ST_IDLE: begin
          if (start) begin
            mode_r         <= mode;
            idx            <= '0;
            busy           <= 1'b1;
            mem_rw_req     <= 1'b1;
            mem_wr_en_pack <= '0;
            state          <= L2C_FLUSH_ST_RD;
          end
        end
        L2C_FLUSH_ST_RD: begin
          if (mem_rw_rdy) begin
            cap_tag    <= mem_rd_tag_pack;
            cap_data   <= mem_rd_data_pack;
            cap_valid  <= mem_rd_valid_pack;
            pend       <= mem_rd_valid_pack & mem_rd_dirty_pack;
            had_pend   <= |(mem_rd_valid_pack & mem_rd_dirty_pack);
            mem_rw_req <= 1'b0;
            state      <= L2C_FLUSH_ST_SCAN;
          end
        end
        L2C_FLUSH_ST_SCAN: begin
          if (pend_found) begin
            way_sel <= pend_way;
            xu_req  <= 1'b1;
            xu_addr <= ADDR_W'({cap_tag[pend_way*TAG_W +: TAG_W], idx, 2'b00});
            xu_data <= cap_data[pend_way*DATA_W +: DATA_W];
            state   <= L2C_FLUSH_ST_WB;
          end else if (mode_r && !had_pend) begin
            state <= L2C_FLUSH_ST_NEXT;
          end else begin
            mem_rw_req        <= 1'b1;
            mem_wr_en_pack    <= '1;
            mem_wr_tag_pack   <= cap_tag;
            mem_wr_data_pack  <= cap_data;
            mem_wr_dirty_pack <= '0;
            mem_wr_valid_pack <= mode_r ? cap_valid : '0;
            state             <= L2C_FLUSH_ST_UPD;
          end
        end
        L2C_FLUSH_ST_WB: begin
          if (xu_ack) begin
            pend[way_sel] <= 1'b0;
            xu_req        <= 1'b0;
            state         <= L2C_FLUSH_ST_SCAN;
          end
        end
        L2C_FLUSH_ST_UPD: begin
          if (mem_rw_rdy) begin
            mem_rw_req     <= 1'b0;
            mem_wr_en_pack <= '0;
            state          <= L2C_FLUSH_ST_NEXT;
          end
        end
        L2C_FLUSH_ST_NEXT: begin
          if (&idx) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= L2C_FLUSH_ST_DONE;
          end else begin
            idx        <= idx + 1'b1;
            mem_rw_req <= 1'b1;
            state      <= L2C_FLUSH_ST_RD;
          end
        end
        L2C_FLUSH_ST_DONE: begin
          state <= L2C_FLUSH_ST_IDLE;
        end
        default: begin
          state <= L2C_FLUSH_ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2c_flush_seq.sv
// Bench for l2c_flush_seq: a small array model and XU responder, with every walk checked
// against writebacks and final array contents predicted from the preloaded contents.
module tb_l2c_flush_seq;
  import l2c_flush_seq_pkg::*;

  localparam int INDEX_W = 2;
  localparam int WAY_NUM = 4;
  localparam int TAG_W   = 28;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int SETS    = 1 << INDEX_W;

  typedef logic [WAY_NUM-1:0][TAG_W-1:0]  tag_set_t;
  typedef logic [WAY_NUM-1:0][DATA_W-1:0] data_set_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      start = 1'b0;
  logic                      mode = 1'b0;
  logic                      busy, done, mem_rw_req;
  logic [INDEX_W-1:0]        mem_rw_index;
  logic [WAY_NUM-1:0]        mem_wr_en_pack, mem_wr_valid_pack, mem_wr_dirty_pack;
  logic [TAG_W*WAY_NUM-1:0]  mem_wr_tag_pack, mem_rd_tag_pack;
  logic [DATA_W*WAY_NUM-1:0] mem_wr_data_pack, mem_rd_data_pack;
  logic                      mem_rw_rdy = 1'b1;
  logic [WAY_NUM-1:0]        mem_rd_valid_pack, mem_rd_dirty_pack;
  logic                      xu_req;
  xu_l2c_cmd_e               xu_cmd;
  logic [ADDR_W-1:0]         xu_addr;
  logic [DATA_W/8-1:0]       xu_data_be;
  logic [DATA_W-1:0]         xu_data;
  logic                      xu_ack = 1'b0;

  always #5 clk = ~clk;

  l2c_flush_seq #(
    .INDEX_W (INDEX_W), .WAY_NUM (WAY_NUM), .TAG_W (TAG_W), .DATA_W (DATA_W), .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .mode (mode), .busy (busy), .done (done),
    .mem_rw_req (mem_rw_req), .mem_rw_index (mem_rw_index), .mem_wr_en_pack (mem_wr_en_pack),
    .mem_wr_tag_pack (mem_wr_tag_pack), .mem_wr_valid_pack (mem_wr_valid_pack),
    .mem_wr_dirty_pack (mem_wr_dirty_pack), .mem_wr_data_pack (mem_wr_data_pack),
    .mem_rw_rdy (mem_rw_rdy), .mem_rd_tag_pack (mem_rd_tag_pack),
    .mem_rd_valid_pack (mem_rd_valid_pack), .mem_rd_dirty_pack (mem_rd_dirty_pack),
    .mem_rd_data_pack (mem_rd_data_pack), .xu_req (xu_req), .xu_cmd (xu_cmd),
    .xu_addr (xu_addr), .xu_data_be (xu_data_be), .xu_data (xu_data), .xu_ack (xu_ack)
  );

  // Live array (m_*) and the contents the next walk starts from (p_*).
  tag_set_t           m_tag [SETS], p_tag [SETS];
  data_set_t          m_data[SETS], p_data[SETS];
  logic [WAY_NUM-1:0] m_valid[SETS], m_dirty[SETS], p_valid[SETS], p_dirty[SETS];
  logic [WAY_NUM-1:0] e_valid[SETS], e_dirty[SETS];

  assign mem_rd_tag_pack   = m_tag[mem_rw_index];
  assign mem_rd_data_pack  = m_data[mem_rw_index];
  assign mem_rd_valid_pack = m_valid[mem_rw_index];
  assign mem_rd_dirty_pack = m_dirty[mem_rw_index];

  int fill_seq = 0;
  int filled_seq = 0;
  int bad_we = 0;
  logic [INDEX_W-1:0]       rd_log[$], wr_log[$], exp_wr[$];
  logic [ADDR_W+DATA_W-1:0] wb_log[$], exp_wb[$];

  always @(posedge clk) begin
    if (fill_seq != filled_seq) begin
      for (int s = 0; s < SETS; s++) begin
        m_tag[s]   <= p_tag[s];
        m_data[s]  <= p_data[s];
        m_valid[s] <= p_valid[s];
        m_dirty[s] <= p_dirty[s];
      end
      filled_seq <= fill_seq;
    end else if (!rst) begin
      if (mem_rw_req && mem_rw_rdy) begin
        if (mem_wr_en_pack == '0) begin
          rd_log.push_back(mem_rw_index);
        end else if (&mem_wr_en_pack) begin
          wr_log.push_back(mem_rw_index);
          m_tag[mem_rw_index]   <= mem_wr_tag_pack;
          m_data[mem_rw_index]  <= mem_wr_data_pack;
          m_valid[mem_rw_index] <= mem_wr_valid_pack;
          m_dirty[mem_rw_index] <= mem_wr_dirty_pack;
        end else begin
          bad_we++;
        end
      end
      if (xu_req && xu_ack) wb_log.push_back({xu_addr, xu_data});
    end
  end

  bit rdy_rand = 1'b0;
  bit ack_hold = 1'b0;
  bit spurious = 1'b0;
  int ack_fixed = 0;
  int ack_wait = 0;
  int ack_target = 0;
  int done_cnt = 0;
  int overlap_errs = 0, drop_errs = 0, stab_errs = 0, pulse_errs = 0;
  bit prev_hs = 1'b0, prev_done = 1'b0;
  logic [ADDR_W-1:0] hold_addr = '0;
  logic [DATA_W-1:0] hold_data = '0;

  // Responders and protocol watchers, all on the falling edge.
  always @(negedge clk) begin
    if (prev_hs && mem_rw_req) drop_errs++;
    if (mem_rw_req && xu_req) overlap_errs++;
    if (done) begin
      done_cnt++;
      if (prev_done || busy) pulse_errs++;
    end
    prev_done = done;
    if (xu_req) begin
      if (xu_cmd != XU_L2C_CMD_WB || xu_data_be != '1) stab_errs++;
      if (ack_wait == 0) begin
        hold_addr = xu_addr;
        hold_data = xu_data;
      end else if (xu_addr !== hold_addr || xu_data !== hold_data) begin
        stab_errs++;
      end
      xu_ack = (ack_wait >= ack_target);
      ack_wait++;
    end else begin
      ack_wait   = 0;
      ack_target = ack_hold ? 1000000 : (ack_fixed >= 0 ? ack_fixed : int'($urandom_range(0, 3)));
      xu_ack     = spurious && ($urandom_range(0, 3) == 0);
    end
    mem_rw_rdy = rdy_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
    prev_hs    = mem_rw_req && mem_rw_rdy;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_clean();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        p_tag[s][w]  = TAG_W'($urandom);
        p_data[s][w] = $urandom;
      end
      p_valid[s] = '1;
      p_dirty[s] = '0;
    end
  endtask

  task automatic fill_random(input int dirty_pct);
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        p_tag[s][w]   = TAG_W'($urandom);
        p_data[s][w]  = $urandom;
        p_valid[s][w] = 1'($urandom_range(0, 1));
        p_dirty[s][w] = ($urandom_range(0, 99) < dirty_pct);
      end
    end
  endtask

  task automatic load_model();
    fill_seq++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Predict the walk from p_*, run it, then compare logs and the final array.
  task automatic run_walk(input bit m, input int mid_start, input bit start_at_done,
                          input int exp_lat);
    int rd_b, wr_b, wb_b, done_b, err_b, lat;
    logic [WAY_NUM-1:0] pend;
    bit wr_set;
    exp_wb.delete();
    exp_wr.delete();
    for (int s = 0; s < SETS; s++) begin
      pend = p_valid[s] & p_dirty[s];
      for (int w = 0; w < WAY_NUM; w++)
        if (pend[w]) exp_wb.push_back({p_tag[s][w], INDEX_W'(s), 2'b00, p_data[s][w]});
      wr_set = (m == 1'b0) || (pend != '0);
      if (wr_set) exp_wr.push_back(INDEX_W'(s));
      e_valid[s] = m ? p_valid[s] : '0;
      e_dirty[s] = wr_set ? '0 : p_dirty[s];
    end
    rd_b   = rd_log.size();
    wr_b   = wr_log.size();
    wb_b   = wb_log.size();
    done_b = done_cnt;
    err_b  = overlap_errs + drop_errs + stab_errs + pulse_errs + bad_we;
    applyStimulus(m);
    lat = 1;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
      start = (mid_start > 0 && lat == mid_start);
    end
    start = 1'b0;
    checkOutput("done_seen", done, 1'b1);
    if (exp_lat >= 0) checkOutput("latency", lat, exp_lat);
    if (start_at_done && done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (6) @(negedge clk);
    checkOutput("busy_idle", busy, 1'b0);
    checkOutput("done_count", done_cnt - done_b, 1);
    checkOutput("rd_count", rd_log.size() - rd_b, SETS);
    if (rd_log.size() - rd_b == SETS)
      for (int s = 0; s < SETS; s++) checkOutput("rd_order", rd_log[rd_b + s], s);
    checkOutput("wr_count", wr_log.size() - wr_b, exp_wr.size());
    if (wr_log.size() - wr_b == exp_wr.size())
      for (int i = 0; i < exp_wr.size(); i++) checkOutput("wr_set", wr_log[wr_b + i], exp_wr[i]);
    checkOutput("wb_count", wb_log.size() - wb_b, exp_wb.size());
    if (wb_log.size() - wb_b == exp_wb.size())
      for (int i = 0; i < exp_wb.size(); i++) checkOutput("wb_addr_data", wb_log[wb_b + i], exp_wb[i]);
    for (int s = 0; s < SETS; s++) begin
      checkOutput("final_valid", m_valid[s], e_valid[s]);
      checkOutput("final_dirty", m_dirty[s], e_dirty[s]);
      checkOutput("final_tag", m_tag[s], p_tag[s]);
      checkOutput("final_data", m_data[s], p_data[s]);
    end
    checkOutput("protocol_errs", overlap_errs + drop_errs + stab_errs + pulse_errs + bad_we, err_b);
  endtask

  initial begin
    int done_b;
    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_mem_req", mem_rw_req, 1'b0);
    checkOutput("rst_xu_req", xu_req, 1'b0);
    checkOutput("rst_index", mem_rw_index, 0);
    checkOutput("rst_wr_en", mem_wr_en_pack, 0);
    rst = 1'b0;

    // All clean: flush then clean, with full-rate array.
    fill_clean();
    load_model();
    run_walk(1'b0, 0, 1'b0, SETS * 4 + 1);
    fill_clean();
    load_model();
    run_walk(1'b1, 0, 1'b0, SETS * 3 + 1);

    // One dirty way in set 1.
    fill_clean();
    p_tag[1][2]   = TAG_W'(32'h5A);
    p_data[1][2]  = 32'hDEADBEEF;
    p_dirty[1][2] = 1'b1;
    load_model();
    run_walk(1'b0, 0, 1'b0, -1);
    if (wb_log.size() > 0) checkOutput("wb_set1_way2", wb_log[wb_log.size() - 1], {32'h5A4, 32'hDEADBEEF});

    // Two dirty ways in set 3 with a stalled XU.
    fill_clean();
    p_dirty[3][0] = 1'b1;
    p_dirty[3][3] = 1'b1;
    ack_fixed = 5;
    load_model();
    run_walk(1'b0, 0, 1'b0, SETS * 4 + 1 + 2 * (1 + 6));

    // Clean mode, single dirty way in set 2.
    fill_clean();
    p_dirty[2][1] = 1'b1;
    ack_fixed = 0;
    load_model();
    run_walk(1'b1, 0, 1'b0, SETS * 3 + 1 + 2 + 1);

    // Reset while a writeback of set 1 is stalled.
    fill_clean();
    p_dirty[1][2] = 1'b1;
    ack_hold = 1'b1;
    load_model();
    done_b = done_cnt;
    applyStimulus(1'b0);
    for (int i = 0; i < 200 && !xu_req; i++) @(negedge clk);
    checkOutput("rst_wb_reached", xu_req, 1'b1);
    checkOutput("rst_wb_set", xu_addr[INDEX_W+1:2], 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_xu_req", xu_req, 1'b0);
    checkOutput("abort_mem_req", mem_rw_req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ack_hold = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("abort_no_done", done_cnt - done_b, 0);
    load_model();
    run_walk(1'b0, 0, 1'b0, -1);

    // Randomized walks with a stalling array, random XU latency, stray acks and
    // start pulses mid-walk and in the done cycle.
    rdy_rand  = 1'b1;
    spurious  = 1'b1;
    ack_fixed = -1;
    for (int it = 0; it < 8; it++) begin
      fill_random(40);
      load_model();
      run_walk(1'($urandom_range(0, 1)), (it % 2 == 1) ? 5 : 0, (it % 3 == 0), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
